// File: rtl/reg_queue.sv
// rtl/reg_queue.sv - first-word fall-through circular queue with sticky overflow/underflow flags
module reg_queue #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       writeEnable,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       readEnable,
    input  logic                       flush,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A push into a full queue still lands when a pop frees the head slot on the same edge.
    assign pop_ok  = readEnable && !empty;
    assign push_ok = writeEnable && (!full || readEnable);

    assign data_out = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (writeEnable && !push_ok) begin
                overflow <= 1'b1;
            end
            if (readEnable && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage is never reset; empty masks stale words on data_out.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_reg_queue.sv
// tb/tb_reg_queue.sv - directed self-checking bench for reg_queue
module tb_reg_queue;

    localparam int WIDTH = 65;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             writeEnable;
    logic [WIDTH-1:0] data_in;
    logic             readEnable;
    logic             flush;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic [2:0]       count;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_fails  = 0;

    reg_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .writeEnable(writeEnable),
        .data_in    (data_in),
        .readEnable (readEnable),
        .flush      (flush),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic we, input logic [WIDTH-1:0] din, input logic re,
                       input logic fl, input logic rst);
        writeEnable = we;
        data_in     = din;
        readEnable  = re;
        flush       = fl;
        reset       = rst;
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
        data_in     = '0;
        readEnable  = 1'b0;
        flush       = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic check_state(input string tag, input int exp_count, input logic [WIDTH-1:0] exp_data,
                               input logic exp_ovf, input logic exp_unf);
        check_val({tag, ".count"},     128'(count),     128'(exp_count));
        check_val({tag, ".data_out"},  128'(data_out),  128'(exp_data));
        check_val({tag, ".empty"},     128'(empty),     128'(exp_count == 0));
        check_val({tag, ".full"},      128'(full),      128'(exp_count == DEPTH));
        check_val({tag, ".overflow"},  128'(overflow),  128'(exp_ovf));
        check_val({tag, ".underflow"}, 128'(underflow), 128'(exp_unf));
    endtask

    initial begin
        logic [WIDTH-1:0] word_a;
        logic [WIDTH-1:0] word_b;
        word_a = 65'h1_0000_0000_0000_0001;
        word_b = 65'h0_FFFF_FFFF_FFFF_FFFF;
        writeEnable = 1'b0;
        data_in     = '0;
        readEnable  = 1'b0;
        flush       = 1'b0;
        reset       = 1'b1;

        // reset, with push/pop/flush also asserted to confirm reset wins
        cyc(1'b1, 65'd5, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_state("reset", 0, '0, 1'b0, 1'b0);

        // wide-word push/pop
        cyc(1'b1, word_a, 1'b0, 1'b0, 1'b0);
        check_state("wide_push1", 1, word_a, 1'b0, 1'b0);
        cyc(1'b1, word_b, 1'b0, 1'b0, 1'b0);
        check_state("wide_push2", 2, word_a, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_state("wide_pop1", 1, word_b, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_state("wide_pop2", 0, '0, 1'b0, 1'b0);

        // fill, overflow, drain
        for (int i = 1; i <= 4; i++) cyc(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
        check_state("fill", 4, 65'd1, 1'b0, 1'b0);
        cyc(1'b1, 65'd5, 1'b0, 1'b0, 1'b0);
        check_state("overflow", 4, 65'd1, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            check_val($sformatf("drain%0d", i), 128'(data_out), 128'(i));
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        check_state("drained", 0, '0, 1'b1, 1'b0);

        // flush clears sticky flag; then push+pop while full
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check_state("flush1", 0, '0, 1'b0, 1'b0);
        for (int i = 11; i <= 14; i++) cyc(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
        check_state("refill", 4, 65'd11, 1'b0, 1'b0);
        cyc(1'b1, 65'd9, 1'b1, 1'b0, 1'b0);
        check_state("full_pushpop", 4, 65'd12, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_state("after3pops", 1, 65'd9, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_state("empty_again", 0, '0, 1'b0, 1'b0);

        // pop on empty alongside a push
        cyc(1'b1, 65'd7, 1'b1, 1'b0, 1'b0);
        check_state("underflow", 1, 65'd7, 1'b0, 1'b1);

        // steady push/pop at count=2 walks the pointers around
        cyc(1'b1, 65'd20, 1'b0, 1'b0, 1'b0);
        check_state("count2", 2, 65'd7, 1'b0, 1'b1);
        begin
            logic [WIDTH-1:0] exp_head [6];
            exp_head = '{65'd7, 65'd20, 65'd21, 65'd22, 65'd23, 65'd24};
            for (int i = 0; i < 6; i++) begin
                check_val($sformatf("wrap_head%0d", i), 128'(data_out), 128'(exp_head[i]));
                cyc(1'b1, WIDTH'(21 + i), 1'b1, 1'b0, 1'b0);
                check_val($sformatf("wrap_count%0d", i), 128'(count), 128'd2);
            end
        end
        check_state("wrapped", 2, 65'd25, 1'b0, 1'b1);
        cyc(1'b1, 65'd99, 1'b1, 1'b1, 1'b0);
        check_state("flush_push", 0, '0, 1'b0, 1'b0);

        // reset mid-operation
        for (int i = 31; i <= 35; i++) cyc(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_state("pre_reset", 3, 65'd32, 1'b1, 1'b0);
        cyc(1'b1, 65'd40, 1'b1, 1'b0, 1'b1);
        check_state("mid_reset", 0, '0, 1'b0, 1'b0);
        cyc(1'b1, 65'd41, 1'b0, 1'b0, 1'b0);
        check_state("post_reset", 1, 65'd41, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/reg_queue.md
REG_QUEUE -- requirements
Module: reg_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 65, meaning the data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of storage entries (power of two, >=2).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 The block SHALL have port writeEnable  input  1  meaning a push request for data_in this cycle.
REQ-006 The block SHALL have port data_in  input  WIDTH  meaning the word to push.
REQ-007 The block SHALL have port readEnable  input  1  meaning a pop request for the head entry this cycle.
REQ-008 The block SHALL have port flush  input  1  meaning a synchronous discard of all stored entries.
REQ-009 The block SHALL have port data_out  output  WIDTH  meaning the current head entry (first-word fall-through).
REQ-010 The block SHALL have port full  output  1  meaning count == DEPTH.
REQ-011 The block SHALL have port empty  output  1  meaning count == 0.
REQ-012 The block SHALL have port count  output  $clog2(DEPTH)+1  meaning the number of valid entries.
REQ-013 The block SHALL have port overflow  output  1  meaning sticky flag for a dropped push.
REQ-014 The block SHALL have port underflow  output  1  meaning sticky flag for an ignored pop.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH x WIDTH with write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 An accepted push SHALL write data_in at the write pointer and advance it by one; an accepted pop SHALL advance the read pointer by one.
REQ-017 data_out SHALL be the entry at the read pointer whenever empty==0, combinationally, with zero pop latency; it SHALL be all-zeros when empty==1.
REQ-018 A pushed word SHALL be visible on data_out the cycle after the push edge when the queue was empty (one-cycle write-to-read latency).
REQ-019 Push while full with no pop SHALL be dropped, SHALL leave storage, pointers and count unchanged, and SHALL set overflow.
REQ-020 Pop while empty SHALL be ignored and SHALL set underflow, including when writeEnable is also high; the push SHALL still be accepted.
REQ-021 Simultaneous push and pop while full SHALL both be accepted; count SHALL stay DEPTH and overflow SHALL NOT be set.
REQ-022 Simultaneous push and pop while 0<count<DEPTH SHALL both be accepted with count unchanged.
REQ-023 count SHALL increment on push-only acceptance, decrement on pop-only acceptance, and never exceed DEPTH or go below 0.
REQ-024 flush SHALL take priority over writeEnable and readEnable: pointers, count, overflow and underflow SHALL clear to 0 on that edge, and concurrent push/pop SHALL be ignored without setting flags.
REQ-025 overflow and underflow SHALL remain set until reset or flush.
REQ-026 full and empty SHALL be derived combinationally from count.

Reset
REQ-027 On a rising clk edge with reset==1, pointers and count SHALL be 0, empty SHALL be 1, full, overflow and underflow SHALL be 0, and data_out SHALL be all-zeros.
REQ-028 reset SHALL take priority over flush, writeEnable and readEnable.
REQ-029 Storage contents SHALL NOT require reset; stale contents SHALL never appear on data_out because empty masks it.
REQ-030 Reset asserted mid-operation SHALL discard all entries in one cycle, with no partial push or pop.

Verification
REQ-031 Bench SHALL cover this scenario: after reset, push 0x1_0000_0000_0000_0001, then 0x0_FFFF_FFFF_FFFF_FFFF -> count=2, data_out=0x1_0000_0000_0000_0001; pop -> data_out=0x0_FFFF_FFFF_FFFF_FFFF, count=1.
REQ-032 Bench SHALL cover this scenario: push words 1,2,3,4 (DEPTH=4) -> full=1; push 5 -> overflow=1, count=4; pop four times -> outputs 1,2,3,4, then empty=1.
REQ-033 Bench SHALL cover this scenario: with full=1, push 9 and pop together -> count=4, overflow=0; after three more pops, data_out=9.
REQ-034 Bench SHALL cover this scenario: pop on empty together with push 7 -> underflow=1, count=1, data_out=7.
REQ-035 Bench SHALL cover this scenario: 6 push/pop cycles at count=2 wrap the pointers past 3 -> FIFO order is preserved; flush with push=1 -> count=0, empty=1, flags=0.
REQ-036 Bench SHALL cover this scenario: reset asserted with count=3 and overflow=1 -> on the next edge count=0, overflow=0, data_out=0.
